// File: rtl/result_writer.sv
// Result writer: drains (dim, fact) pairs from the probe engine FIFO into a host result buffer.
// Optional RESULT_WRITER_TAIL_COUNT_EN appends a final write of the accepted-pair count.
module result_writer #(
   parameter int MAX_OUTSTANDING = 64,
   parameter int OUTSTANDING_W   = 10
) (
   input  logic        clk,
   input  logic        rst,
   output logic        done,
   input  logic        engine_done_in,
   input  logic [47:0] out_base_in,
   input  logic [63:0] max_results_in,
   input  logic        result_empty_in,
   output logic        result_read_en_out,
   input  logic [63:0] result_dim_in,
   input  logic [63:0] result_fact_in,
   input  logic        wr_rq_stall_in,
   output logic        wr_rq_vld_out,
   output logic [47:0] wr_rq_vadr_out,
   output logic [63:0] wr_rq_data_out,
   input  logic        wr_rs_vld_in,
   output logic [63:0] result_count_out,
   output logic [63:0] dropped_count_out,
   output logic        overflow_out
);

`ifdef RESULT_WRITER_TAIL_COUNT_EN
   typedef enum logic [2:0] {IDLE, WR_DIM, WR_FACT, TAIL, TAIL_WAIT, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, WR_DIM, WR_FACT, DONE} state_t;
`endif

   localparam logic [OUTSTANDING_W-1:0] OS_MAX = OUTSTANDING_W'(MAX_OUTSTANDING);

   state_t                   state_q, state_d;
   logic [47:0]              ptr_q, ptr_d;
   logic [63:0]              dim_q, dim_d;
   logic [63:0]              fact_q, fact_d;
   logic [OUTSTANDING_W-1:0] os_q, os_d;
   logic [63:0]              res_cnt_q, res_cnt_d;
   logic [63:0]              drop_cnt_q, drop_cnt_d;
   logic                     ovf_q, ovf_d;

   logic                     rd_en;
   logic                     req_vld;
   logic [47:0]              req_adr;
   logic [63:0]              req_data;
   logic                     accept;
   logic                     os_room;

   function automatic logic [63:0] sat_inc(input logic [63:0] v);
      return (&v) ? v : v + 64'd1;
   endfunction

   assign os_room = (os_q < OS_MAX);
   assign accept  = req_vld && !wr_rq_stall_in;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      dim_d      = dim_q;
      fact_d     = fact_q;
      res_cnt_d  = res_cnt_q;
      drop_cnt_d = drop_cnt_q;
      ovf_d      = ovf_q;
      rd_en      = 1'b0;
      req_vld    = 1'b0;
      req_adr    = 48'd0;
      req_data   = 64'd0;

      case (state_q)
         IDLE: begin
            if (!result_empty_in) begin
               rd_en = 1'b1;
               if (res_cnt_q < max_results_in) begin
                  dim_d     = result_dim_in;
                  fact_d    = result_fact_in;
                  res_cnt_d = sat_inc(res_cnt_q);
                  state_d   = WR_DIM;
               end else begin
                  drop_cnt_d = sat_inc(drop_cnt_q);
                  ovf_d      = 1'b1;
               end
            end else if (engine_done_in && (os_q == '0)) begin
`ifdef RESULT_WRITER_TAIL_COUNT_EN
               state_d = TAIL;
`else
               state_d = DONE;
`endif
            end
         end
         WR_DIM: begin
            req_vld  = os_room;
            req_adr  = ptr_q;
            req_data = dim_q;
            if (accept) begin
               ptr_d   = ptr_q + 48'd8;
               state_d = WR_FACT;
            end
         end
         WR_FACT: begin
            req_vld  = os_room;
            req_adr  = ptr_q;
            req_data = fact_q;
            if (accept) begin
               ptr_d   = ptr_q + 48'd8;
               state_d = IDLE;
            end
         end
`ifdef RESULT_WRITER_TAIL_COUNT_EN
         // Tail slot sits just past the full-capacity region of the buffer.
         TAIL: begin
            req_vld  = os_room;
            req_adr  = out_base_in + {max_results_in[43:0], 4'b0000};
            req_data = res_cnt_q;
            if (accept) state_d = TAIL_WAIT;
         end
         TAIL_WAIT: begin
            if (os_q == '0) state_d = DONE;
         end
`endif
         DONE: begin
         end
         default: state_d = IDLE;
      endcase

      // An ack at zero has no request to match (e.g. one issued before a reset).
      os_d = os_q;
      if (accept && !wr_rs_vld_in)
         os_d = os_q + 1'b1;
      else if (!accept && wr_rs_vld_in && (os_q != '0))
         os_d = os_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= out_base_in;
         os_q       <= '0;
         res_cnt_q  <= 64'd0;
         drop_cnt_q <= 64'd0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         os_q       <= os_d;
         res_cnt_q  <= res_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   // Pair payload is only observed while a write state is active.
   always_ff @(posedge clk) begin
      dim_q  <= dim_d;
      fact_q <= fact_d;
   end

   assign done               = (state_q == DONE);
   assign result_read_en_out = rd_en;
   assign wr_rq_vld_out      = req_vld;
   assign wr_rq_vadr_out     = req_adr;
   assign wr_rq_data_out     = req_data;
   assign result_count_out   = res_cnt_q;
   assign dropped_count_out  = drop_cnt_q;
   assign overflow_out       = ovf_q;

endmodule

// File: tb/tb_result_writer.sv
// Scoreboard bench for result_writer: FIFO source, write sink with ack control, expected-write queue.
module tb_result_writer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        done;
   logic        engine_done_in = 1'b0;
   logic [47:0] out_base_in = 48'd0;
   logic [63:0] max_results_in = 64'd0;
   logic        result_empty_in = 1'b1;
   logic        result_read_en_out;
   logic [63:0] result_dim_in = 64'd0;
   logic [63:0] result_fact_in = 64'd0;
   logic        wr_rq_stall_in = 1'b0;
   logic        wr_rq_vld_out;
   logic [47:0] wr_rq_vadr_out;
   logic [63:0] wr_rq_data_out;
   logic        wr_rs_vld_in = 1'b0;
   logic [63:0] result_count_out;
   logic [63:0] dropped_count_out;
   logic        overflow_out;

   result_writer #(.MAX_OUTSTANDING(2), .OUTSTANDING_W(10)) dut (
      .clk                (clk),
      .rst                (rst),
      .done               (done),
      .engine_done_in     (engine_done_in),
      .out_base_in        (out_base_in),
      .max_results_in     (max_results_in),
      .result_empty_in    (result_empty_in),
      .result_read_en_out (result_read_en_out),
      .result_dim_in      (result_dim_in),
      .result_fact_in     (result_fact_in),
      .wr_rq_stall_in     (wr_rq_stall_in),
      .wr_rq_vld_out      (wr_rq_vld_out),
      .wr_rq_vadr_out     (wr_rq_vadr_out),
      .wr_rq_data_out     (wr_rq_data_out),
      .wr_rs_vld_in       (wr_rs_vld_in),
      .result_count_out   (result_count_out),
      .dropped_count_out  (dropped_count_out),
      .overflow_out       (overflow_out)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {logic [63:0] dim; logic [63:0] fact;} pair_t;
   typedef struct packed {logic [47:0] adr; logic [63:0] data;} wr_t;
   pair_t fifo_q[$];
   wr_t   exp_q[$];

   logic [47:0] m_ptr;
   logic [63:0] m_cnt, m_drop;
   logic        m_ovf;

   int ack_mode   = 0;   // 0: ack every pending write, 1: hold acks
   int ack_grant  = 0;
   bit sync_grant = 1'b0;
   bit stall_force = 1'b0;
   bit stall_arm  = 1'b0;
   int stall_left = 0;
   int pending    = 0;
   int acc_cnt    = 0;
   bit rd_seen    = 1'b0;

   // Environment: FIFO source, stall and ack driver, write sink; all on the falling edge.
   always @(negedge clk) begin
      wr_t e;
      bit  ack;
      if (rd_seen && fifo_q.size() > 0) fifo_q.delete(0);

      if (stall_arm && wr_rq_vld_out && wr_rq_vadr_out == 48'h1018) begin
         stall_left = 5;
         stall_arm  = 1'b0;
      end
      if (stall_left > 0) begin
         wr_rq_stall_in = 1'b1;
         stall_left--;
         check("stall_adr", {16'd0, wr_rq_vadr_out}, 64'h1018);
         check("stall_dat", wr_rq_data_out, 64'd4);
         check("stall_nopop", {63'd0, result_read_en_out}, 64'd0);
      end else begin
         wr_rq_stall_in = stall_force;
      end

      ack = 1'b0;
      if (pending > 0) begin
         if (ack_mode == 0) ack = 1'b1;
         else if (ack_grant > 0) begin
            ack = 1'b1;
            ack_grant--;
         end else if (sync_grant && wr_rq_vld_out && !wr_rq_stall_in) begin
            ack = 1'b1;
            sync_grant = 1'b0;
         end
      end
      wr_rs_vld_in = ack;
      if (ack) pending--;

      if (wr_rq_vld_out && !wr_rq_stall_in && !rst) begin
         acc_cnt++;
         pending++;
         check("wr_expected", {63'd0, exp_q.size() > 0}, 64'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_adr", {16'd0, wr_rq_vadr_out}, {16'd0, e.adr});
            check("wr_dat", wr_rq_data_out, e.data);
         end
      end

      result_empty_in = (fifo_q.size() == 0);
      result_dim_in   = result_empty_in ? 64'd0 : fifo_q[0].dim;
      result_fact_in  = result_empty_in ? 64'd0 : fifo_q[0].fact;
      #1;
      rd_seen = result_read_en_out && !rst;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input logic [47:0] base, input logic [63:0] max);
      rst = 1'b1;
      engine_done_in = 1'b0;
      out_base_in = base;
      max_results_in = max;
      cyc(1);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_vld", {63'd0, wr_rq_vld_out}, 64'd0);
      check("rst_adr", {16'd0, wr_rq_vadr_out}, 64'd0);
      check("rst_rden", {63'd0, result_read_en_out}, 64'd0);
      check("rst_cnt", result_count_out, 64'd0);
      check("rst_drop", dropped_count_out, 64'd0);
      check("rst_ovf", {63'd0, overflow_out}, 64'd0);
      cyc(1);
      exp_q.delete();
      m_ptr = base;
      m_cnt = 64'd0;
      m_drop = 64'd0;
      m_ovf = 1'b0;
      acc_cnt = 0;
      rst = 1'b0;
      cyc(1);
   endtask

   task automatic push_pair(input logic [63:0] d, input logic [63:0] f);
      pair_t p;
      p.dim = d;
      p.fact = f;
      fifo_q.push_back(p);
      if (m_cnt < max_results_in) begin
         exp_q.push_back({m_ptr, d});
         exp_q.push_back({m_ptr + 48'd8, f});
         m_ptr = m_ptr + 48'd16;
         m_cnt++;
      end else begin
         m_drop++;
         m_ovf = 1'b1;
      end
   endtask

   task automatic run_finish(input string tag);
      int i;
`ifdef RESULT_WRITER_TAIL_COUNT_EN
      exp_q.push_back({out_base_in + max_results_in[47:0] * 48'd16, m_cnt});
`endif
      engine_done_in = 1'b1;
      for (i = 0; i < 500 && !done; i++) cyc(1);
      check({tag, "_done"}, {63'd0, done}, 64'd1);
      check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_acked"}, 64'(pending), 64'd0);
      check({tag, "_cnt"}, result_count_out, m_cnt);
      check({tag, "_drop"}, dropped_count_out, m_drop);
      check({tag, "_ovf"}, {63'd0, overflow_out}, {63'd0, m_ovf});
      cyc(2);
      check({tag, "_sticky"}, {63'd0, done}, 64'd1);
   endtask

   initial begin
      cyc(2);
      // Basic three-pair run.
      do_reset(48'h1000, 64'd4);
      push_pair(64'd1, 64'd2);
      push_pair(64'd3, 64'd4);
      push_pair(64'd5, 64'd6);
      run_finish("basic");

      // Stall held during the fact write of pair 2.
      do_reset(48'h1000, 64'd4);
      stall_arm = 1'b1;
      push_pair(64'd1, 64'd2);
      push_pair(64'd3, 64'd4);
      push_pair(64'd5, 64'd6);
      run_finish("stall");
      check("stall_seen", {63'd0, stall_arm}, 64'd0);

      // Capacity overflow.
      do_reset(48'h2000, 64'd2);
      for (int i = 0; i < 5; i++) push_pair(64'(i + 10), 64'(i + 100));
      run_finish("ovf");

      // Zero capacity.
      do_reset(48'h3000, 64'd0);
      push_pair(64'hAA, 64'hBB);
      push_pair(64'hCC, 64'hDD);
      run_finish("zero");

      // Outstanding limit with withheld acks.
      do_reset(48'h4000, 64'd8);
      ack_mode = 1;
      push_pair(64'h11, 64'h12);
      push_pair(64'h13, 64'h14);
      push_pair(64'h15, 64'h16);
      cyc(12);
      check("os_cap_acc", 64'(acc_cnt), 64'd2);
      check("os_cap_vld", {63'd0, wr_rq_vld_out}, 64'd0);
      ack_grant = 1;
      sync_grant = 1'b1;
      cyc(12);
      check("os_sim_acc", 64'(acc_cnt), 64'd4);
      check("os_sim_vld", {63'd0, wr_rq_vld_out}, 64'd0);
      ack_mode = 0;
      run_finish("os");

      // Reset during WR_DIM with one write outstanding, then a late ack.
      do_reset(48'h5000, 64'd8);
      ack_mode = 1;
      push_pair(64'h21, 64'h22);
      push_pair(64'h23, 64'h24);
      cyc(12);
      stall_force = 1'b1;
      ack_grant = 1;
      cyc(3);
      check("abort_pre_vld", {63'd0, wr_rq_vld_out}, 64'd1);
      check("abort_pre_adr", {16'd0, wr_rq_vadr_out}, 64'h5010);
      do_reset(48'h5000, 64'd8);
      stall_force = 1'b0;
      ack_mode = 0;
      cyc(3);
      check("late_ack_used", 64'(pending), 64'd0);
      push_pair(64'd7, 64'd8);
      push_pair(64'd9, 64'd10);
      run_finish("abort");

      // Address wrap at the top of the 48-bit space.
      do_reset(48'hFFFF_FFFF_FFF8, 64'd4);
      push_pair(64'd11, 64'd22);
      run_finish("wrap");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/result_writer.md
Name: result_writer

Overview:
- Sits directly downstream of the probe engine.
- Pops matched (dim, fact) result pairs from the engine's first-word-fall-through output FIFO and writes them to a contiguous host-memory result buffer as two sequential 64-bit writes per pair.
- Tracks outstanding write acknowledgements and enforces the buffer capacity.
- Asserts done only once every result is committed to memory.

Parameters:
MAX_OUTSTANDING, 64, maximum unacknowledged write requests in flight (1..1023)
OUTSTANDING_W, 10, width of the outstanding counter; must hold MAX_OUTSTANDING

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
done  output  1  all results written and acknowledged; sticky until rst
engine_done_in  input  1  engine has finished producing results
out_base_in  input  48  byte address of result buffer; 8-byte aligned
max_results_in  input  64  buffer capacity in pairs
result_empty_in  input  1  engine output FIFO empty
result_read_en_out  output  1  pop engine output FIFO this cycle
result_dim_in  input  64  dim-table value at FIFO head (valid when !empty)
result_fact_in  input  64  fact-table value at FIFO head
wr_rq_stall_in  input  1  memory cannot accept a request this cycle
wr_rq_vld_out  output  1  write request valid
wr_rq_vadr_out  output  48  write byte address
wr_rq_data_out  output  64  write data
wr_rs_vld_in  input  1  one write acknowledgement
result_count_out  output  64  pairs accepted into the buffer
dropped_count_out  output  64  pairs discarded after capacity reached
overflow_out  output  1  capacity reached and at least one pair dropped; sticky

Behaviour:
- Reset (synchronous, rst high at clk edge): state=IDLE. All outputs 0. Address pointer=out_base_in. Counters 0. Mid-operation reset aborts an in-flight request without waiting for acks; acks arriving afterwards are ignored (counter held at 0, no underflow).
- Inputs are static from reset deassertion to done.
- FIFO handshake: result_read_en_out = (state==IDLE) && !result_empty_in (combinational). Data sampled on the same edge as the pop.
- Popped pair, result_count_out < max_results_in: register dim/fact, result_count_out += 1, go to WR_DIM.
- Popped pair, result_count_out == max_results_in: discard it, dropped_count_out += 1, overflow_out=1, stay in IDLE.
- WR_DIM: wr_rq_vld_out=1 iff outstanding < MAX_OUTSTANDING. Address=pointer, data=dim.
  - Accepted on a cycle with vld && !wr_rq_stall_in: pointer += 8, go to WR_FACT.
  - Stall holds vld, address and data stable.
- WR_FACT: same request rules with data=fact. On accept: pointer += 8, return to IDLE.
- Throughput: one pair per 3 cycles with no stall. Pop-to-first-request latency is 1 cycle.
- Outstanding counter: +1 on accept, -1 on wr_rs_vld_in; simultaneous accept and ack leaves it unchanged. An ack at 0 is ignored.
- Address arithmetic: 48-bit, wraps modulo 2^48, no error.
- Counters: 64-bit, saturate at all-ones.
- Done condition: state==IDLE && engine_done_in && result_empty_in && outstanding==0 → go to DONE (or TAIL, see below). done=1 in DONE. DONE is terminal until rst; no pops in DONE.
- max_results_in==0: every pair is dropped and no writes are issued.

Optional Feature:
- Macro RESULT_WRITER_TAIL_COUNT_EN.
- When defined: when the done condition is met, enter TAIL and issue one extra write.
  - Address = out_base_in + 16*max_results_in (low 48 bits).
  - Data = result_count_out.
  - The request obeys the stall and outstanding rules.
  - After it is accepted and outstanding returns to 0, enter DONE.
- When undefined: go directly to DONE. The TAIL state and its logic are absent.

Test Plan:
- Base 0x1000, max 4, three pairs (1,2),(3,4),(5,6), no stalls → writes 0x1000=1, 0x1008=2, 0x1010=3, 0x1018=4, 0x1020=5, 0x1028=6, each acked; result_count=3; done after the last ack. With the macro defined, an extra write 0x1040=3 precedes done.
- Same traffic with wr_rq_stall_in high for 5 cycles during WR_FACT of pair 2 → address/data held at 0x1018/4 for those cycles; no extra pop; final memory image identical.
- max 2, five pairs → four writes only; result_count=2, dropped_count=3, overflow_out=1; done asserts after engine_done and drain.
- MAX_OUTSTANDING=2, acks withheld → vld drops after 2 accepts; first ack re-enables issue. A simultaneous accept and ack leaves outstanding at 2.
- Reset asserted during WR_DIM with 1 outstanding, then a late ack → all outputs 0 next cycle; late ack ignored; new run from base address is correct.
- Base 0xFFFF_FFFF_FFF8, one pair → writes at 0xFFFF_FFFF_FFF8 then 0x0 (wrap).
